// File: rtl/timer_ctrl.sv
// BCD mm:ss-style countdown (tens 0..5, ones 0..9) with a start/pause/cancel FSM and prescaled one-second tick.
// Optional alarm pulse on reaching DONE is built only when TIMER_ALARM_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | time may be loaded; start with non-zero time begins counting
// RUN     | prescaler counts, time decrements once per TICK_DIV cycles
// PAUSED  | prescaler and time frozen until start or cancel
// DONE    | time reached 00; start or cancel returns to IDLE
module timer_ctrl #(
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned ALARM_LEN = 8
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    input  logic       load_en,
    input  logic [2:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [2:0] tens,
    output logic [3:0] ones,
    output logic [1:0] state,
    output logic       tick,
    output logic       zero,
    output logic       done,
    output logic       alarm
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    generate
        if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_bad_tick_div
            $error("timer_ctrl: TICK_DIV out of range 2..65535");
        end
        if (ALARM_LEN < 1 || ALARM_LEN > 255) begin : g_bad_alarm_len
            $error("timer_ctrl: ALARM_LEN out of range 1..255");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [2:0]      tens_q, tens_d;
    logic [3:0]      ones_q, ones_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            tick_q, tick_d;
    logic            done_q, done_d;

    logic            due;
    logic            dec_to_zero;
    logic [2:0]      dec_tens;
    logic [3:0]      dec_ones;

    assign zero = (tens_q == 3'd0) && (ones_q == 4'd0);

    always_comb begin
        due         = (presc_q == PRESC_MAX);
        dec_to_zero = (tens_q == 3'd0) && (ones_q == 4'd1);
        dec_tens    = tens_q;
        dec_ones    = ones_q - 4'd1;
        if (ones_q == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = tens_q - 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        tick_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A load in the same cycle as start wins, so RUN is never entered with a stale 00.
                if (cancel) begin
                    tens_d = 3'd0;
                    ones_d = 4'd0;
                end else if (load_en) begin
                    tens_d = (load_tens > 3'd5) ? 3'd5 : load_tens;
                    ones_d = (load_ones > 4'd9) ? 4'd9 : load_ones;
                end else if (start && !pause && !zero) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    tens_d  = 3'd0;
                    ones_d  = 4'd0;
                    presc_d = '0;
                end else begin
                    if (due) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        tens_d  = dec_tens;
                        ones_d  = dec_ones;
                    end else if (!pause) begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                    if (due && dec_to_zero) begin
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end
                end
            end
            ST_PAUSED: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    tens_d  = 3'd0;
                    ones_d  = 4'd0;
                    presc_d = '0;
                end else if (start && !pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (cancel || (start && !pause)) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            tens_q  <= 3'd0;
            ones_q  <= 4'd0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign tens  = tens_q;
    assign ones  = ones_q;
    assign state = state_q;
    assign tick  = tick_q;
    assign done  = done_q;

`ifdef TIMER_ALARM_EN
    logic       alarm_q, alarm_d;
    logic [7:0] alarm_cnt_q, alarm_cnt_d;

    // Down-counter loaded on DONE entry; alarm stays high while the count has not run out.
    always_comb begin
        alarm_d     = 1'b0;
        alarm_cnt_d = 8'd0;
        if (state_d == ST_DONE) begin
            if (state_q != ST_DONE) begin
                alarm_d     = 1'b1;
                alarm_cnt_d = 8'(ALARM_LEN - 1);
            end else if (alarm_cnt_q != 8'd0) begin
                alarm_d     = 1'b1;
                alarm_cnt_d = alarm_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 8'd0;
        end else begin
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized and directed checks of timer_ctrl against a seconds-count reference model.
module tb_timer_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int ALARM_LEN = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic       clock = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0, pause = 1'b0, cancel = 1'b0, load_en = 1'b0;
    logic [2:0] load_tens = 3'd0;
    logic [3:0] load_ones = 4'd0;
    logic [2:0] tens;
    logic [3:0] ones;
    logic [1:0] state;
    logic       tick, zero, done, alarm;

    timer_ctrl #(.TICK_DIV(TICK_DIV), .ALARM_LEN(ALARM_LEN)) dut (
        .clock(clock), .clr(clr), .start(start), .pause(pause), .cancel(cancel),
        .load_en(load_en), .load_tens(load_tens), .load_ones(load_ones),
        .tens(tens), .ones(ones), .state(state), .tick(tick), .zero(zero),
        .done(done), .alarm(alarm)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: time kept as plain seconds, prescaler as an integer phase.
    int m_mode, m_secs, m_presc, m_tick, m_age;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_alarm();
`ifdef TIMER_ALARM_EN
        return (m_mode == M_DONE && m_age < ALARM_LEN) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_secs = 0; m_presc = 0; m_tick = 0; m_age = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit l,
                              input int lt, input int lo);
        int old_mode;
        old_mode = m_mode;
        m_tick = 0;
        case (m_mode)
            M_IDLE: begin
                if (c) m_secs = 0;
                else if (l) m_secs = (lt > 5 ? 5 : lt) * 10 + (lo > 9 ? 9 : lo);
                else if (s && !p && m_secs != 0) begin m_mode = M_RUN; m_presc = 0; end
            end
            M_RUN: begin
                if (c) begin m_mode = M_IDLE; m_secs = 0; m_presc = 0; end
                else begin
                    if (m_presc == TICK_DIV - 1) begin
                        m_presc = 0; m_tick = 1; m_secs = m_secs - 1;
                    end else if (!p) m_presc = m_presc + 1;
                    if (m_secs == 0) m_mode = M_DONE;
                    else if (p) m_mode = M_PAUSED;
                end
            end
            M_PAUSED: begin
                if (c) begin m_mode = M_IDLE; m_secs = 0; m_presc = 0; end
                else if (s && !p) m_mode = M_RUN;
            end
            default: begin
                if (c || (s && !p)) begin m_mode = M_IDLE; m_presc = 0; end
            end
        endcase
        if (m_mode == M_DONE) m_age = (old_mode == M_DONE) ? m_age + 1 : 0;
    endtask

    task automatic compare_all();
        check("tens",  tens,  m_secs / 10);
        check("ones",  ones,  m_secs % 10);
        check("state", state, m_mode);
        check("tick",  tick,  m_tick);
        check("zero",  zero,  (m_secs == 0) ? 1 : 0);
        check("done",  done,  (m_mode == M_DONE) ? 1 : 0);
        check("alarm", alarm, m_alarm());
    endtask

    task automatic step(input bit s, input bit p, input bit c, input bit l,
                        input int lt, input int lo);
        @(negedge clock);
        start = s; pause = p; cancel = c; load_en = l;
        load_tens = 3'(lt); load_ones = 4'(lo);
        @(posedge clock);
        model_step(s, p, c, l, lt, lo);
        #1;
        compare_all();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_and_start(input int lt, input int lo);
        step(0, 0, 0, 1, lt, lo);
        step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int cnt, budget;
        model_reset();
        #12;
        compare_all();
        @(negedge clock);
        clr = 1'b0;

        // 03 counts down to DONE in three ticks
        load_and_start(0, 3);
        check("run_entered", state, M_RUN);
        cnt = 0; budget = 0;
        while (m_mode != M_DONE && budget < 40) begin
            idle_step(); budget++;
            if (tick) cnt++;
        end
        check("ticks_to_done", cnt, 3);
        check("done_flag", done, 1);
        check("cycles_to_done", budget, 3 * TICK_DIV);
        step(1, 0, 0, 0, 0, 0);

        // 10 -> 09 after one tick
        load_and_start(1, 0);
        repeat (TICK_DIV) idle_step();
        check("dec_tens_10", tens, 0);
        check("dec_ones_10", ones, 9);
        check("dec_zero_10", zero, 0);
        step(0, 0, 1, 0, 0, 0);

        // clamping and load ignored while running
        step(0, 0, 0, 1, 7, 12);
        check("clamp_tens", tens, 5);
        check("clamp_ones", ones, 9);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        check("load_in_run", tens, 5);

        // pause two cycles after a tick; resume picks up the held phase
        budget = 0;
        while (!tick && budget < 20) begin idle_step(); budget++; end
        check("tick_seen", tick, 1);
        idle_step();
        idle_step();
        step(0, 1, 0, 0, 0, 0);
        check("paused", state, M_PAUSED);
        repeat (10) step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        cnt = 0;
        while (!tick && cnt < 20) begin idle_step(); cnt++; end
        check("resume_latency", cnt, 2);

        // cancel beats pause and start
        step(1, 1, 1, 0, 0, 0);
        check("cancel_state", state, M_IDLE);
        check("cancel_time", {tens, ones}, 0);

        // asynchronous clear mid-count
        load_and_start(2, 5);
        repeat (5) idle_step();
        #2 clr = 1'b1;
        #1;
        model_reset();
        check("clr_async", {tens, ones, state, tick, done, alarm}, 0);
        @(negedge clock);
        clr = 1'b0;
        step(0, 0, 0, 1, 0, 2);
        check("after_clr_load", ones, 2);

        // alarm length after DONE
        step(1, 0, 0, 0, 0, 0);
        budget = 0;
        while (m_mode != M_DONE && budget < 40) begin idle_step(); budget++; end
        cnt = alarm ? 1 : 0;
        repeat (ALARM_LEN + 4) begin idle_step(); if (alarm) cnt++; end
`ifdef TIMER_ALARM_EN
        check("alarm_len", cnt, ALARM_LEN);
`else
        check("alarm_len", cnt, 0);
`endif
        step(1, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit s, p, c, l;
            int lt, lo;
            s  = ($urandom_range(99) < 30);
            p  = ($urandom_range(99) < 8);
            c  = ($urandom_range(99) < 2);
            l  = ($urandom_range(99) < 15);
            lt = ($urandom_range(3) == 0) ? $urandom_range(7) : 0;
            lo = $urandom_range(15);
            step(s, p, c, l, lt, lo);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: clock cycles per one-second tick, legal range 2..65535.
REQ-002 SHALL have parameter ALARM_LEN, default 8: alarm pulse length in cycles, legal range 1..255.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: start or resume request, level sampled each cycle.
REQ-006 SHALL have port pause, input, 1: pause request.
REQ-007 SHALL have port cancel, input, 1: abort and clear the time.
REQ-008 SHALL have port load_en, input, 1: load the preset time.
REQ-009 SHALL have port load_tens, input, 3: preset tens-of-seconds digit.
REQ-010 SHALL have port load_ones, input, 4: preset ones digit in BCD.
REQ-011 SHALL have port tens, output, 3: current tens digit, 0..5.
REQ-012 SHALL have port ones, output, 4: current ones digit, 0..9.
REQ-013 SHALL have port state, output, 2: FSM state encoded IDLE=0, RUN=1, PAUSED=2, DONE=3.
REQ-014 SHALL have port tick, output, 1: one-cycle pulse on each one-second decrement.
REQ-015 SHALL have port zero, output, 1: combinational, high when tens==0 and ones==0.
REQ-016 SHALL have port done, output, 1: high while state==DONE.
REQ-017 SHALL have port alarm, output, 1: alarm pulse (see Configuration).

Function
REQ-018 SHALL give priority cancel > pause > start among simultaneous requests; all outputs except zero SHALL be registered, and state changes SHALL be visible one cycle after the request.
REQ-019 In IDLE, load_en SHALL load the digits next cycle, clamping load_ones>9 to 9 and load_tens>5 to 5; load_en SHALL be ignored in all other states.
REQ-020 In IDLE, start with a non-zero time SHALL enter RUN with the prescaler at 0; start with time 00 SHALL leave the block in IDLE.
REQ-021 In RUN, the prescaler SHALL count 0..TICK_DIV-1; the cycle it holds TICK_DIV-1 SHALL wrap it to 0, pulse tick, and decrement the time.
REQ-022 Decrement SHALL be BCD mod-60: ones 1..9 -> ones-1; ones 0 -> ones=9 and tens-1.
REQ-023 A decrement that yields 00 SHALL move RUN -> DONE in the same edge.
REQ-024 RUN + pause SHALL enter PAUSED, hold the prescaler and the time, and still apply any decrement due that same cycle.
REQ-025 PAUSED + start SHALL return to RUN with the prescaler resuming from its held value.
REQ-026 cancel in RUN or PAUSED SHALL enter IDLE with the time cleared to 00 and the prescaler cleared, with no tick that cycle.
REQ-027 DONE + start or cancel SHALL return to IDLE with the time kept at 00.
REQ-028 tick SHALL never assert outside RUN, and the time SHALL never wrap below 00.

Reset
REQ-029 clr high SHALL immediately force state=IDLE, tens=0, ones=0, prescaler=0, tick=0, done=0, alarm=0, asynchronously, including mid-count.
REQ-030 After clr deasserts, the block SHALL accept requests from the next rising edge.

Configuration
REQ-031 With macro TIMER_ALARM_EN defined, alarm SHALL assert on the first cycle of DONE and stay high for exactly ALARM_LEN cycles, or until exit from DONE if that comes first.
REQ-032 Without TIMER_ALARM_EN, alarm SHALL be tied to 0, with no alarm counter logic and the port still present.

Verification (TICK_DIV=4)
REQ-033 Load 0/3, start -> RUN; ticks every 4 cycles; time 03 -> 02 -> 01 -> 00; DONE and done=1 at the third tick edge.
REQ-034 Load 1/0, run one tick -> time 09 (tens=0, ones=9), no wrap below 00, zero=0.
REQ-035 Load 7/12 -> time 59 by clamping; load_en in RUN -> no change.
REQ-036 Pause 2 cycles after a tick, hold 10 cycles, then start -> the next tick arrives 2 cycles after resume.
REQ-037 Assert pause, cancel and start together in RUN -> IDLE, time 00, no tick; assert clr mid-RUN -> all outputs 0 asynchronously.
REQ-038 TIMER_ALARM_EN defined, ALARM_LEN=8 -> alarm high exactly 8 cycles after DONE; undefined -> alarm constant 0.
